// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the bit slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle LSB-first adder over one full_adder slice with start/busy/done handshake.
// Define BIT_SERIAL_ADDER_SUB_EN to add a 'sub' input that turns the operation into a - b.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_ff),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c_ff   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
`ifdef BIT_SERIAL_ADDER_SUB_EN
                        // Two's-complement subtract: invert b and force carry-in.
                        b_sr  <= sub ? ~b : b;
                        c_ff  <= sub ? 1'b1 : cin;
`else
                        b_sr  <= b;
                        c_ff  <= cin;
`endif
                        cnt   <= '0;
                        state <= S_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    c_ff   <= fa_co;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {fa_s, res_sr[WIDTH-1:1]};
                        cout  <= fa_co;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: arithmetic/timeline model plus directed vectors.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_err = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles since acceptance (-1 = idle) and the arithmetic result.
    int           m_t = -1;
    logic         m_valid = 1'b0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = -1;
            m_sum = '0;
            m_cout = 1'b0;
            m_valid = 1'b1;
        end else if (m_t < 0) begin
            if (start) begin
                m_t = 0;
                if (sub)
                    m_pend = {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
                else
                    m_pend = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
            end
        end else begin
            m_t++;
            if (m_t == W)
                {m_cout, m_sum} = m_pend;
            else if (m_t == W + 1)
                m_t = -1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 32'(busy), 32'(m_t >= 0 && m_t < W));
            check("done", 32'(done), 32'(m_t == W));
            check("sum", 32'(sum), 32'(m_sum));
            check("cout", 32'(cout), 32'(m_cout));
        end
        if (done === 1'b1) done_pulses++;
    end

    // Launches one operation, scrambles inputs after acceptance, waits for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic ts, input logic [W-1:0] exp_s, input logic exp_c,
                          input string name);
        int  nbusy = 0;
        bit  got = 0;
        @(posedge clk); #2;
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (done) got = 1;
            if (busy) nbusy++;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(W));
        check({name, "_sum"}, 32'(sum), 32'(exp_s));
        check({name, "_cout"}, 32'(cout), 32'(exp_c));
        @(negedge clk);
    endtask

    initial begin
        int pulses0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);

        pulses0 = done_pulses;
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, "add_3c_5a");
        check("add_single_done", 32'(done_pulses - pulses0), 32'd1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "carry_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "carry_ff_ff_c1");
        run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, "add_12_34_c1");

        // Second start during shifting must be ignored.
        pulses0 = done_pulses;
        @(posedge clk); #2;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 a = 8'hF0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("ignored_start_pulses", 32'(done_pulses - pulses0), 32'd1);
        check("ignored_start_sum", 32'(sum), 32'h02);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Reset in the middle of a shift sequence.
        @(posedge clk); #2;
        a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, "after_abort");

`ifdef BIT_SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1, "sub_10_03");
        run_op(8'h03, 8'h10, 1'b1, 1'b1, 8'hF3, 1'b0, "sub_03_10");
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
